// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared types and helpers for the DIV/IDIV sequential divider.
//   DivState_t     - controller states (IDLE, PREP, DIVIDE, FIXUP)
//   DIV_ITER_WORD  - iterations for a DX:AX / r16 divide
//   DIV_ITER_BYTE  - iterations for an AX / r8 divide
//   DIV_CNT_W      - width of the iteration counter
//   restore_step() - one restoring shift-subtract step
// -----------------------------------------------------------------------------
package divider_pkg;

   localparam int DIV_CNT_W = 5;

   localparam logic [DIV_CNT_W-1:0] DIV_ITER_WORD = 5'd16;
   localparam logic [DIV_CNT_W-1:0] DIV_ITER_BYTE = 5'd8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PREP   = 2'd1,
      DIVIDE = 2'd2,
      FIXUP  = 2'd3
   } DivState_t;

   // Partial remainder plus a shift register that feeds dividend bits out of
   // its MSB and collects quotient bits into its LSB.
   typedef struct packed {
      logic [15:0] rem;
      logic [15:0] shr;
   } DivStep_t;

   // Restoring step. The partial remainder is always below the divisor, so
   // the 17-bit trial value never overflows and the result fits 16 bits.
   function automatic DivStep_t restore_step(
      input logic [15:0] rem,
      input logic [15:0] shr,
      input logic [15:0] dvs
   );
      DivStep_t    res;
      logic [16:0] trial;
      logic [16:0] diff;
      trial = {rem, shr[15]};
      diff  = trial - {1'b0, dvs};
      if (trial >= {1'b0, dvs}) begin
         res.rem = diff[15:0];
         res.shr = {shr[14:0], 1'b1};
      end else begin
         res.rem = trial[15:0];
         res.shr = {shr[14:0], 1'b0};
      end
      return res;
   endfunction

endpackage

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Multi-cycle 8086-style DIV/IDIV unit, one quotient bit per clock.
// Ports:
//   clk        - clock, all state on rising edge
//   reset_n    - asynchronous active-low reset
//   start      - begin a divide (only honoured in IDLE)
//   is_8_bit   - 1: AX / r8, 0: DX:AX / r16
//   is_signed  - 1: IDIV, 0: DIV
//   dividend   - [31:0] word mode, [15:0] byte mode
//   divisor    - [15:0] word mode, [7:0] byte mode
//   quotient   - result (byte mode upper byte is 0), held until next completion
//   remainder  - result (byte mode upper byte is 0), held until next completion
//   complete   - one-cycle pulse, results valid while high
//   error      - divide error, qualified by complete
//   busy       - high whenever not IDLE
// -----------------------------------------------------------------------------
module divider
   import divider_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        is_8_bit,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [15:0] divisor,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        complete,
   output logic        error,
   output logic        busy
);

   DivState_t             state_q, state_d;
   logic [DIV_CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]           dvd_q, dvd_d;
   logic [15:0]           dvs_q, dvs_d;
   logic                  is8_q, is8_d;
   logic                  sgn_q, sgn_d;
   logic                  qneg_q, qneg_d;
   logic                  rneg_q, rneg_d;
   logic [15:0]           rem_q, rem_d;
   logic [15:0]           shr_q, shr_d;
   logic [15:0]           quot_q, quot_d;
   logic [15:0]           remo_q, remo_d;
   logic                  err_q, err_d;
   logic                  cmpl_q, cmpl_d;

   // Operand conditioning used in PREP (signs only count for IDIV)
   logic                  dvd_neg_s, dvs_neg_s;
   logic [31:0]           dvd_mag_w_s;
   logic [15:0]           dvd_mag_b_s;
   logic [15:0]           dvs_mag_w_s;
   logic [7:0]            dvs_mag_b_s;
   logic [15:0]           hi_s, lo_s, mag_dvs_s;
   logic                  uov_s, sov_s, prep_err_s;
   DivStep_t              step_s;
   logic [15:0]           q_w_s, r_w_s;
   logic [7:0]            q_b_s, r_b_s;

   assign dvd_neg_s   = sgn_q & (is8_q ? dvd_q[15] : dvd_q[31]);
   assign dvs_neg_s   = sgn_q & (is8_q ? dvs_q[7]  : dvs_q[15]);
   assign dvd_mag_w_s = dvd_neg_s ? (32'd0 - dvd_q)       : dvd_q;
   assign dvd_mag_b_s = dvd_neg_s ? (16'd0 - dvd_q[15:0]) : dvd_q[15:0];
   assign dvs_mag_w_s = dvs_neg_s ? (16'd0 - dvs_q)       : dvs_q;
   assign dvs_mag_b_s = dvs_neg_s ? (8'd0 - dvs_q[7:0])   : dvs_q[7:0];

   // Divide starts with the high half already in the partial remainder, so
   // only N steps are needed; byte mode left-aligns its low byte in shr.
   assign hi_s      = is8_q ? {8'h00, dvd_mag_b_s[15:8]}   : dvd_mag_w_s[31:16];
   assign lo_s      = is8_q ? {dvd_mag_b_s[7:0], 8'h00}    : dvd_mag_w_s[15:0];
   assign mag_dvs_s = is8_q ? {8'h00, dvs_mag_b_s}         : dvs_mag_w_s;

   // |q| > 0x7FFF (0x7F) exactly when |dividend| >= |divisor| << 15 (<< 7);
   // this also rejects -32768 / -128 like the 8086 does.
   assign uov_s      = (hi_s >= mag_dvs_s);
   assign sov_s      = is8_q ? (dvd_mag_b_s >= {1'b0, dvs_mag_b_s, 7'd0})
                             : (dvd_mag_w_s >= {1'b0, dvs_mag_w_s, 15'd0});
   assign prep_err_s = (mag_dvs_s == 16'd0) | uov_s | (sgn_q & sov_s);

   assign step_s = restore_step(rem_q, shr_q, dvs_q);

   // Sign fixup: truncation toward zero, remainder follows the dividend
   assign q_w_s = qneg_q ? (16'd0 - shr_q)      : shr_q;
   assign q_b_s = qneg_q ? (8'd0 - shr_q[7:0])  : shr_q[7:0];
   assign r_w_s = rneg_q ? (16'd0 - rem_q)      : rem_q;
   assign r_b_s = rneg_q ? (8'd0 - rem_q[7:0])  : rem_q[7:0];

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      is8_d   = is8_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      rem_d   = rem_q;
      shr_d   = shr_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      err_d   = err_q;
      cmpl_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               is8_d   = is_8_bit;
               sgn_d   = is_signed;
               state_d = PREP;
            end else begin
               state_d = IDLE;
            end
         end
         PREP: begin
            if (prep_err_s) begin
               quot_d  = 16'd0;
               remo_d  = 16'd0;
               err_d   = 1'b1;
               cmpl_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               rem_d   = hi_s;
               shr_d   = lo_s;
               dvs_d   = mag_dvs_s;
               qneg_d  = dvd_neg_s ^ dvs_neg_s;
               rneg_d  = dvd_neg_s;
               cnt_d   = is8_q ? DIV_ITER_BYTE : DIV_ITER_WORD;
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            rem_d = step_s.rem;
            shr_d = step_s.shr;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = FIXUP;
            end else begin
               state_d = DIVIDE;
            end
         end
         FIXUP: begin
            quot_d  = is8_q ? {8'h00, q_b_s} : q_w_s;
            remo_d  = is8_q ? {8'h00, r_b_s} : r_w_s;
            err_d   = 1'b0;
            cmpl_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= 32'd0;
         dvs_q   <= 16'd0;
         is8_q   <= 1'b0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         rem_q   <= 16'd0;
         shr_q   <= 16'd0;
         quot_q  <= 16'd0;
         remo_q  <= 16'd0;
         err_q   <= 1'b0;
         cmpl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         is8_q   <= is8_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         rem_q   <= rem_d;
         shr_q   <= shr_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         err_q   <= err_d;
         cmpl_q  <= cmpl_d;
      end
   end

   assign quotient  = quot_q;
   assign remainder = remo_q;
   assign error     = err_q;
   assign complete  = cmpl_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider: expected results are queued when a start
// is driven and compared when complete pulses, including latency in edges.
// -----------------------------------------------------------------------------
module tb_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        is_8_bit = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = 32'd0;
   logic [15:0] divisor = 16'd0;
   logic [15:0] quotient, remainder;
   logic        complete, error, busy;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        err;
      int          lat;
      int          se;
   } exp_t;

   exp_t        sb[$];
   exp_t        e_m;
   int          total = 0;
   int          bad = 0;
   int          edge_cnt = 0;
   int          n_done = 0;
   int          n0;
   logic [15:0] last_q = 16'd0;
   logic        prev_cmpl = 1'b0;

   divider dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .is_8_bit  (is_8_bit),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .complete  (complete),
      .error     (error),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] q, input logic [15:0] r, input logic err, input int lat);
      exp_t e;
      e.q = q; e.r = r; e.err = err; e.lat = lat; e.se = 0;
      return e;
   endfunction

   // Reference: integer division of the sign/zero-extended operands
   function automatic exp_t model(input bit is8, input bit sgn, input logic [31:0] dvd, input logic [15:0] dvs);
      exp_t               e;
      longint             a, b, q, r, lim;
      logic signed [31:0] s32;
      logic signed [15:0] s16;
      logic signed [7:0]  s8;
      logic [63:0]        qv, rv;
      bit                 err;
      if (is8) begin
         s16 = dvd[15:0];
         s8  = dvs[7:0];
         a   = sgn ? longint'(s16) : longint'(dvd[15:0]);
         b   = sgn ? longint'(s8)  : longint'(dvs[7:0]);
         lim = sgn ? 127 : 255;
      end else begin
         s32 = dvd;
         s16 = dvs;
         a   = sgn ? longint'(s32) : longint'(dvd);
         b   = sgn ? longint'(s16) : longint'(dvs);
         lim = sgn ? 32767 : 65535;
      end
      q = 0; r = 0;
      if (b == 0) begin
         err = 1'b1;
      end else begin
         q   = a / b;
         r   = a % b;
         err = (q > lim) || (q < -lim);
      end
      qv = q; rv = r;
      e.se  = 0;
      e.err = err;
      if (err) begin
         e.q = 16'd0; e.r = 16'd0; e.lat = 2;
      end else begin
         e.q   = is8 ? {8'h00, qv[7:0]} : qv[15:0];
         e.r   = is8 ? {8'h00, rv[7:0]} : rv[15:0];
         e.lat = is8 ? 11 : 19;
      end
      return e;
   endfunction

   // Completion monitor: pop expected result and compare
   always @(negedge clk) begin
      if (complete && prev_cmpl) chk("complete_pulse", 32'(complete), 32'd0);
      prev_cmpl = complete;
      if (complete) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_complete", 32'd1, 32'd0);
         end else begin
            e_m = sb.pop_front();
            chk("quotient",  32'(quotient),  32'(e_m.q));
            chk("remainder", 32'(remainder), 32'(e_m.r));
            chk("error",     32'(error),     32'(e_m.err));
            chk("latency",   32'(edge_cnt - e_m.se + 1), 32'(e_m.lat));
            last_q = e_m.q;
         end
      end
   end

   // Called at a falling edge: start is sampled on the next rising edge
   task automatic do_op(input bit is8, input bit sgn, input logic [31:0] dvd,
                        input logic [15:0] dvs, input exp_t e);
      is_8_bit  = is8;
      is_signed = sgn;
      dividend  = dvd;
      divisor   = dvs;
      start     = 1'b1;
      e.se      = edge_cnt + 1;
      sb.push_back(e);
      @(negedge clk);
      start     = 1'b0;
      chk("busy_running", 32'(busy), 32'd1);
      dividend  = $urandom;
      divisor   = 16'($urandom);
      is_8_bit  = 1'($urandom);
      is_signed = 1'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("drain_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic op_m(input bit is8, input bit sgn, input logic [31:0] dvd, input logic [15:0] dvs);
      do_op(is8, sgn, dvd, dvs, model(is8, sgn, dvd, dvs));
      wait_idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [15:0] rs;
      bit          r8, rsg;
      #2;
      chk("rst_busy",     32'(busy),      32'd0);
      chk("rst_complete", 32'(complete),  32'd0);
      chk("rst_error",    32'(error),     32'd0);
      chk("rst_quotient", 32'(quotient),  32'd0);
      chk("rst_remain",   32'(remainder), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed cases with hand-computed results
      do_op(1'b0, 1'b0, 32'h0001_0000, 16'h0002, mk(16'h8000, 16'h0000, 1'b0, 19)); wait_idle();
      do_op(1'b1, 1'b1, 32'hABCD_FFF9, 16'h5502, mk(16'h00FD, 16'h00FF, 1'b0, 11)); wait_idle();
      do_op(1'b0, 1'b0, 32'h1234_5678, 16'h0000, mk(16'h0000, 16'h0000, 1'b1, 2));  wait_idle();
      do_op(1'b0, 1'b0, 32'h0002_0000, 16'h0002, mk(16'h0000, 16'h0000, 1'b1, 2));  wait_idle();
      do_op(1'b0, 1'b1, 32'hFFFF_0000, 16'h0002, mk(16'h0000, 16'h0000, 1'b1, 2));  wait_idle();
      do_op(1'b1, 1'b1, 32'h0000_FF80, 16'h0001, mk(16'h0000, 16'h0000, 1'b1, 2));  wait_idle();
      do_op(1'b1, 1'b1, 32'h0000_007F, 16'h0001, mk(16'h007F, 16'h0000, 1'b0, 11)); wait_idle();
      do_op(1'b0, 1'b1, 32'h0000_0007, 16'hFFFE, mk(16'hFFFD, 16'h0001, 1'b0, 19)); wait_idle();
      do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 16'hFFFF, mk(16'h0000, 16'h0000, 1'b1, 2));  wait_idle();
      do_op(1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, mk(16'hFFFF, 16'hFFFE, 1'b0, 19)); wait_idle();
      do_op(1'b1, 1'b0, 32'h0000_00FF, 16'h0001, mk(16'h00FF, 16'h0000, 1'b0, 11)); wait_idle();
      repeat (3) @(negedge clk);
      chk("held_q", 32'(quotient), 32'(last_q));

      // Start accepted in the completion cycle
      do_op(1'b0, 1'b0, 32'h0000_1234, 16'h0010, mk(16'h0123, 16'h0004, 1'b0, 19));
      for (int i = 0; i < 40 && !complete; i++) @(negedge clk);
      do_op(1'b1, 1'b0, 32'h0000_0064, 16'h0007, mk(16'h000E, 16'h0002, 1'b0, 11));
      wait_idle();

      // Start re-pulsed mid-divide is ignored
      n0 = n_done;
      do_op(1'b0, 1'b0, 32'h0000_9999, 16'h0003, mk(16'h3333, 16'h0000, 1'b0, 19));
      repeat (3) @(negedge clk);
      dividend = 32'h0000_0005; divisor = 16'h0001; is_8_bit = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (25) @(negedge clk);
      chk("single_complete", 32'(n_done - n0), 32'd1);

      // Reset in the middle of a divide abandons it
      n0 = n_done;
      do_op(1'b0, 1'b0, 32'h0001_0000, 16'h0003, mk(16'h5555, 16'h0001, 1'b0, 19));
      repeat (6) @(negedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_busy",     32'(busy),      32'd0);
      chk("midrst_complete", 32'(complete),  32'd0);
      chk("midrst_quotient", 32'(quotient),  32'd0);
      chk("midrst_remain",   32'(remainder), 32'd0);
      chk("midrst_error",    32'(error),     32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("no_complete_after_rst", 32'(n_done - n0), 32'd0);
      do_op(1'b0, 1'b0, 32'h0001_0000, 16'h0002, mk(16'h8000, 16'h0000, 1'b0, 19)); wait_idle();
      do_op(1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, mk(16'h00FD, 16'h00FF, 1'b0, 11)); wait_idle();

      // Random operands against the integer reference
      for (int n = 0; n < 40; n++) begin
         rd  = 32'($urandom) >> $urandom_range(0, 31);
         rs  = 16'($urandom) >> $urandom_range(0, 16);
         r8  = 1'($urandom);
         rsg = 1'($urandom);
         if ($urandom_range(0, 1) == 1) rd = 32'd0 - rd;
         if ($urandom_range(0, 1) == 1) rs = 16'd0 - rs;
         op_m(r8, rsg, rd, rs);
      end

      wait_idle();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameters: none; 8/16-bit operation SHALL be selected at run time by is_8_bit.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin a DIV/IDIV; sampled only in IDLE.
REQ-005 is_8_bit  input  1  1 = byte divide (AX / r8), 0 = word divide (DX:AX / r16).
REQ-006 is_signed  input  1  1 = IDIV semantics, 0 = DIV semantics.
REQ-007 dividend  input  32  word mode uses [31:0]; byte mode uses [15:0] and ignores [31:16].
REQ-008 divisor  input  16  word mode uses [15:0]; byte mode uses [7:0] and ignores [15:8].
REQ-009 quotient  output  16  result; byte mode drives [15:8]=0.
REQ-010 remainder  output  16  result; byte mode drives [15:8]=0.
REQ-011 complete  output  1  one-cycle pulse; quotient, remainder and error are valid during it.
REQ-012 error  output  1  divide error (divide-by-zero or quotient overflow), qualified by complete.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 States SHALL be IDLE, PREP, DIVIDE, FIXUP; IDLE->PREP on start, PREP->DIVIDE (or IDLE on error), DIVIDE->FIXUP after N iterations, FIXUP->IDLE.
REQ-015 N SHALL be 16 in word mode and 8 in byte mode.
REQ-016 Operands, is_8_bit and is_signed SHALL be latched on the edge sampling start; later input changes SHALL have no effect.
REQ-017 PREP SHALL form magnitudes: absolute values when is_signed, raw values otherwise.
REQ-018 PREP SHALL flag error when the divisor is zero.
REQ-019 PREP SHALL flag unsigned overflow when dividend high half >= divisor (word: [31:16] vs [15:0]; byte: [15:8] vs [7:0]).
REQ-020 PREP SHALL flag signed overflow when the quotient magnitude exceeds 0x7FFF/0x7F (word/byte), whether the result sign is positive or negative; -32768 and -128 SHALL raise error, as on the 8086.
REQ-021 DIVIDE SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first.
REQ-022 FIXUP SHALL negate the quotient when the operand signs differ and give the remainder the sign of the dividend (truncation toward zero), applied only when is_signed.
REQ-023 Normal latency: complete SHALL pulse in the cycle following the (N+3)th rising edge counted from the edge sampling start (19 for word, 11 for byte).
REQ-024 Error latency: complete and error SHALL pulse after the 2nd edge; quotient and remainder SHALL then be 0.
REQ-025 On a normal completion, error SHALL be 0.
REQ-026 quotient, remainder and error SHALL be registered and held until the next completion.
REQ-027 complete SHALL be high for exactly one cycle per accepted start.
REQ-028 start while busy SHALL be ignored, with no queuing.
REQ-029 start in the completion cycle SHALL be accepted, because the state is IDLE in that cycle.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, busy=0, complete=0, error=0, quotient=0, remainder=0, and clear the iteration counter.
REQ-031 Reset mid-operation SHALL abandon the division with no complete pulse.
REQ-032 The first start after reset_n rises SHALL behave normally.

Structure
REQ-033 The shared package SHALL hold: the DivState_t enum, DIV_ITER_WORD=16, DIV_ITER_BYTE=8, and the 5-bit iteration counter width.
REQ-034 The ALUOp_DIV/ALUOp_IDIV decode to start/is_signed SHALL reside in the instantiating core, not in this block.
REQ-035 There SHALL be no sub-module; the restoring step SHALL be a package function.

Verification
REQ-036 Word DIV 0x0001_0000 / 0x0002 -> quotient=0x8000, remainder=0x0000, error=0, complete 19 edges after start.
REQ-037 Byte IDIV dividend=0xFFF9 (-7), divisor=0x02 -> quotient=0x00FD, remainder=0x00FF, complete after 11 edges.
REQ-038 Word DIV divisor=0 -> complete and error after 2 edges, quotient=remainder=0.
REQ-039 Word DIV 0x0002_0000 / 0x0002 -> error (overflow).
REQ-040 Word IDIV 0xFFFF_0000 / 0x0002 (quotient -32768) -> error.
REQ-041 start re-pulsed at edge 5 of a running division -> ignored, single complete pulse.
REQ-042 reset_n low at edge 8 -> busy=0 immediately, no complete pulse.
REQ-043 Next start after the REQ-042 reset -> correct result.
